// File: rtl/seq_bit_serializer_if.sv
// rtl/seq_bit_serializer_if.sv - parallel word in / serial bit out signal bundle
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;

  // Word producer / serial consumer side
  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done
  );

  // Serializer side
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output ser_out,
    output ser_valid,
    output word_done
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - word-to-bit serializer with one-word holding register
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_bit_serializer_if.slave  bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_adv;
  logic             xfer;
  logic             last_bit;
  logic             emitting;

  // Ready depends only on the holding register, never on data_valid
  assign bus.data_ready = ~hold_full_q;
  assign xfer           = bus.data_valid & ~hold_full_q;
  assign emitting       = (state_q == SHIFT);
  assign last_bit       = emitting && (cnt_q == LAST_CNT);

  assign bus.ser_valid  = emitting;
  assign bus.word_done  = last_bit;
  assign bus.ser_out    = emitting & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);

  // Shifter advanced by one bit toward the output end
  always_comb begin
    shift_adv = shift_q;
    if (MSB_FIRST) shift_adv = {shift_q[WIDTH-2:0], 1'b0};
    else           shift_adv = {1'b0, shift_q[WIDTH-1:1]};
  end

  // Next-state: load, shift, hand off from holding register or go idle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (hold_full_q) begin
            // data_ready is low here, so no new word can collide with the handoff
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shift_d = bus.data_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_adv;
          cnt_d   = cnt_q + 1'b1;
          if (xfer) begin
            hold_d      = bus.data_in;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops the in-flight and held words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb/tb_seq_bit_serializer.sv - directed self-checking bench for seq_bit_serializer
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_bit_serializer_if #(.WIDTH(8)) bus_m ();
  seq_bit_serializer_if #(.WIDTH(8)) bus_l ();

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  always #5 clk = ~clk;

  // Outputs held in reset and just after release
  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b0;
    bus_m.data_in = 8'h00; bus_m.data_valid = 1'b0;
    bus_l.data_in = 8'h00; bus_l.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_msb_outputs: got %b want 1000 (ready,valid,out,done)", got);
    end
    got = {bus_l.data_ready, bus_l.ser_valid, bus_l.ser_out, bus_l.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_lsb_outputs: got %b want 1000 (ready,valid,out,done)", got);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL after_reset_outputs: got %b want 1000 (ready,valid,out,done)", got);
    end
  endtask

  // Single 8'hB5, MSB first
  task automatic test_single_word();
    logic [7:0] exp_bits;
    logic [2:0] got;
    logic [2:0] exp;
    logic       wd;
    exp_bits = 8'b10110101;
    bus_m.data_in = 8'hB5; bus_m.data_valid = 1'b1;
    @(negedge clk);
    bus_m.data_valid = 1'b0; bus_m.data_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      wd  = (i == 8);
      exp = {1'b1, exp_bits[8-i], wd};
      got = {bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL single_b5 cycle %0d: got %b want %b (valid,out,done)", i, got, exp);
      end
      @(negedge clk);
    end
    got = {bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 3'b000) begin
      n_bad++;
      $display("FAIL single_b5 idle cycle 9: got %b want 000", got);
    end
  endtask

  // 8'hFF then 8'h00 with valid held: holding register path
  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    logic [3:0]  got;
    logic [3:0]  exp;
    logic        rdy;
    logic        wd;
    exp_bits = 16'hFF00;
    bus_m.data_in = 8'hFF; bus_m.data_valid = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      rdy = !(i >= 2 && i <= 8);
      wd  = (i == 8) || (i == 16);
      exp = {rdy, 1'b1, exp_bits[16-i], wd};
      got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %b want %b (ready,valid,out,done)", i, got, exp);
      end
      if (i == 1) bus_m.data_in = 8'h00;
      if (i == 2) bus_m.data_valid = 1'b0;
      @(negedge clk);
    end
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL back_to_back idle cycle 17: got %b want 1000", got);
    end
  endtask

  // LSB-first instance, 8'h01
  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    logic [2:0] got;
    logic [2:0] exp;
    logic       wd;
    exp_bits = 8'b10000000;
    bus_l.data_in = 8'h01; bus_l.data_valid = 1'b1;
    @(negedge clk);
    bus_l.data_valid = 1'b0; bus_l.data_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      wd  = (i == 8);
      exp = {1'b1, exp_bits[8-i], wd};
      got = {bus_l.ser_valid, bus_l.ser_out, bus_l.word_done};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL lsb_first_01 cycle %0d: got %b want %b (valid,out,done)", i, got, exp);
      end
      @(negedge clk);
    end
    got = {bus_l.ser_valid, bus_l.ser_out, bus_l.word_done};
    n_cmp++;
    if (got !== 3'b000) begin
      n_bad++;
      $display("FAIL lsb_first_01 idle cycle 9: got %b want 000", got);
    end
  endtask

  // 8'h07 then 8'hE0 offered on the last-bit cycle with hold empty
  task automatic test_word_on_last_bit();
    logic [15:0] exp_bits;
    logic [3:0]  got;
    logic [3:0]  exp;
    logic        wd;
    exp_bits = 16'b00000111_11100000;
    bus_m.data_in = 8'h07; bus_m.data_valid = 1'b1;
    @(negedge clk);
    bus_m.data_valid = 1'b0; bus_m.data_in = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      wd  = (i == 8) || (i == 16);
      exp = {1'b1, 1'b1, exp_bits[16-i], wd};
      got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL last_bit_handoff cycle %0d: got %b want %b (ready,valid,out,done)", i, got, exp);
      end
      if (i == 8) begin
        bus_m.data_in = 8'hE0; bus_m.data_valid = 1'b1;
      end
      if (i == 9) begin
        bus_m.data_valid = 1'b0; bus_m.data_in = 8'h00;
      end
      @(negedge clk);
    end
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL last_bit_handoff idle cycle 17: got %b want 1000", got);
    end
  endtask

  // Reset during bit 4 of 8'hAA with 8'h55 held, then 8'h0F
  task automatic test_reset_mid_word();
    logic [7:0] exp_bits;
    logic [3:0] got;
    logic [3:0] exp;
    logic       wd;
    bus_m.data_in = 8'hAA; bus_m.data_valid = 1'b1;
    @(negedge clk);
    bus_m.data_in = 8'h55;
    @(negedge clk);
    bus_m.data_valid = 1'b0; bus_m.data_in = 8'h00;
    repeat (2) @(negedge clk);
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_word_bit4: got %b want 0100 (ready,valid,out,done)", got);
    end
    rst = 1'b0;
    #1;
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_word_reset_immediate: got %b want 1000", got);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
      n_cmp++;
      if (got !== 4'b1000) begin
        n_bad++;
        $display("FAIL mid_word_no_residue cycle %0d: got %b want 1000", i, got);
      end
    end
    exp_bits = 8'b00001111;
    bus_m.data_in = 8'h0F; bus_m.data_valid = 1'b1;
    @(negedge clk);
    bus_m.data_valid = 1'b0; bus_m.data_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      wd  = (i == 8);
      exp = {1'b1, 1'b1, exp_bits[8-i], wd};
      got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL after_reset_0f cycle %0d: got %b want %b (ready,valid,out,done)", i, got, exp);
      end
      @(negedge clk);
    end
    got = {bus_m.data_ready, bus_m.ser_valid, bus_m.ser_out, bus_m.word_done};
    n_cmp++;
    if (got !== 4'b1000) begin
      n_bad++;
      $display("FAIL after_reset_0f idle cycle 9: got %b want 1000", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_word_on_last_bit();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
